// File: rtl/player_input_conditioner_pkg.sv
// Shared button map for the player input path and the VGA game core.
package player_input_conditioner_pkg;

    // Bit position of each button inside one player's 4-bit group
    localparam int BTN_LEFT        = 0;
    localparam int BTN_RIGHT       = 1;
    localparam int BTN_UP          = 2;
    localparam int BTN_SHOT        = 3;
    localparam int BTNS_PER_PLAYER = 4;
    localparam int NUM_PLAYERS     = 2;

    // Total raw button lines; player p owns [4p+3:4p]
    localparam int NUM_BTNS = BTNS_PER_PLAYER * NUM_PLAYERS;

endpackage

// File: rtl/player_input_conditioner_debounce.sv
// Single-button conditioner: two-flop synchroniser, persistence counter and
// accepted (stable) level. rise is a one-cycle pulse in the first cycle the
// accepted level reads 1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk50mhz,
    input  logic reset,
    input  logic btn_async,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    assign differ = (sync1 != stable);
    assign accept = differ && (cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk50mhz) begin
        // NOTE: sequential state is always assigned with <= so every flop samples
        // the pre-edge value of its neighbours; = here would collapse the two
        // synchroniser stages into one.
        if (reset) begin
            // Reset to "pressed" so a button held through reset never looks like
            // a fresh press once the chain fills with real samples.
            sync0 <= 1'b1;
            sync1 <= 1'b1;
        end else begin
            sync0 <= btn_async;
            sync1 <= sync0;
        end
    end

    // Persistence counter and accepted level; the counter clears whenever the
    // synced level agrees, so only an unbroken run can reach CNT_LAST
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b1;
            rise   <= 1'b0;
        end else begin
            rise <= accept & sync1;
            if (!differ) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                // Cannot pass CNT_LAST: reaching it while unequal always accepts
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_input_conditioner.sv
// Front end of the VGA game core: debounces both players' buttons, resolves
// left+right conflicts and turns up/shot presses into one-frame requests.
module player_input_conditioner
    import player_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                   clk50mhz,
    input  logic                   reset,
    input  logic [NUM_BTNS-1:0]    btn_raw,
    input  logic                   frame_tick,
    output logic [NUM_PLAYERS-1:0] left_o,
    output logic [NUM_PLAYERS-1:0] right_o,
    output logic [NUM_PLAYERS-1:0] up_o,
    output logic [NUM_PLAYERS-1:0] shot_o,
    output logic [NUM_BTNS-1:0]    stable_o
);

    // Settle counter parks at SETTLE_LAST; outputs may load real values from
    // the edge on which it reaches SETTLE_LAST onwards.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES + 4);
    localparam logic [CNT_W-1:0] SETTLE_OPEN = CNT_W'(DEBOUNCE_CYCLES + 3);

    logic [CNT_W-1:0]       settle_cnt;
    logic                   settle_open;
    logic [NUM_BTNS-1:0]    stable;
    logic [NUM_BTNS-1:0]    rise;
    logic [NUM_PLAYERS-1:0] left_n;
    logic [NUM_PLAYERS-1:0] right_n;
    logic [NUM_PLAYERS-1:0] up_rise;
    logic [NUM_PLAYERS-1:0] shot_rise;
    logic [NUM_PLAYERS-1:0] up_pend;
    logic [NUM_PLAYERS-1:0] shot_pend;

    assign settle_open = (settle_cnt >= SETTLE_OPEN);

    // Settle counter from reset release, saturating at SETTLE_LAST
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk50mhz (clk50mhz),
            .reset    (reset),
            .btn_async(btn_raw[b]),
            .stable   (stable[b]),
            .rise     (rise[b])
        );
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam int BASE = p * BTNS_PER_PLAYER;

        // Opposing directions cancel: both held means no movement
        assign left_n[p]    = stable[BASE + BTN_LEFT]  & ~stable[BASE + BTN_RIGHT];
        assign right_n[p]   = stable[BASE + BTN_RIGHT] & ~stable[BASE + BTN_LEFT];
        assign up_rise[p]   = rise[BASE + BTN_UP];
        assign shot_rise[p] = rise[BASE + BTN_SHOT];

        // Movement buttons are consumed as levels; their press pulses are not needed
        logic unused_move_rise;
        assign unused_move_rise = rise[BASE + BTN_LEFT] ^ rise[BASE + BTN_RIGHT];
    end

    // Registered outputs, pending request flags and frame-aligned requests;
    // everything is held at 0 until the settle window closes
    always_ff @(posedge clk50mhz) begin
        if (reset || !settle_open) begin
            left_o    <= '0;
            right_o   <= '0;
            up_o      <= '0;
            shot_o    <= '0;
            stable_o  <= '0;
            up_pend   <= '0;
            shot_pend <= '0;
        end else begin
            left_o   <= left_n;
            right_o  <= right_n;
            stable_o <= stable;
            if (frame_tick) begin
                // A press landing on the tick itself joins the frame now starting
                up_o      <= up_pend | up_rise;
                shot_o    <= shot_pend | shot_rise;
                up_pend   <= '0;
                shot_pend <= '0;
            end else begin
                up_pend   <= up_pend | up_rise;
                shot_pend <= shot_pend | shot_rise;
            end
        end
    end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Randomised scoreboard bench for player_input_conditioner with a short
// debounce window so every behaviour is reached quickly.
module tb_player_input_conditioner;
    import player_input_conditioner_pkg::*;

    localparam int D  = 8;
    localparam int CW = 5;

    logic       clk50mhz = 1'b0;
    logic       reset    = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] btn_raw  = 8'h00;
    logic [1:0] left_o, right_o, up_o, shot_o;
    logic [7:0] stable_o;

    player_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clk50mhz  (clk50mhz),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .frame_tick(frame_tick),
        .left_o    (left_o),
        .right_o   (right_o),
        .up_o      (up_o),
        .shot_o    (shot_o),
        .stable_o  (stable_o)
    );

    always #10 clk50mhz = ~clk50mhz;

    typedef struct packed {
        logic [1:0] left;
        logic [1:0] right;
        logic [1:0] up;
        logic [1:0] shot;
        logic [7:0] stable;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // ---------------- behavioural reference model ----------------
    // The model keeps the list of synchronised samples and accepts a new level
    // once the last D samples all disagree with the accepted one.
    logic [7:0] raw_prev;       // raw sample taken one edge earlier
    logic [7:0] syn_hist[$];    // synchronised level seen after each edge
    logic [7:0] m_level;        // accepted levels
    logic [7:0] m_new_press;    // buttons accepted as pressed on the last edge
    logic [1:0] m_up_req;
    logic [1:0] m_shot_req;
    int         m_edges;
    obs_t       m_out;

    task automatic model_edge(input logic rst, input logic [7:0] raw, input logic tick);
        logic       open;
        logic       all_other;
        logic [1:0] new_up;
        logic [1:0] new_shot;
        if (rst) begin
            raw_prev    = 8'hFF;
            syn_hist.delete();
            m_level     = 8'hFF;
            m_new_press = 8'h00;
            m_up_req    = 2'b00;
            m_shot_req  = 2'b00;
            m_edges     = 0;
            m_out       = '0;
        end else begin
            if (m_edges < 1000) m_edges++;
            open = (m_edges >= D + 4);
            if (!open) begin
                m_out      = '0;
                m_up_req   = 2'b00;
                m_shot_req = 2'b00;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    m_out.left[p]  = m_level[4*p+BTN_LEFT]  && !m_level[4*p+BTN_RIGHT];
                    m_out.right[p] = m_level[4*p+BTN_RIGHT] && !m_level[4*p+BTN_LEFT];
                    new_up[p]      = m_new_press[4*p+BTN_UP];
                    new_shot[p]    = m_new_press[4*p+BTN_SHOT];
                end
                m_out.stable = m_level;
                if (tick) begin
                    m_out.up   = m_up_req | new_up;
                    m_out.shot = m_shot_req | new_shot;
                    m_up_req   = 2'b00;
                    m_shot_req = 2'b00;
                end else begin
                    m_up_req   = m_up_req | new_up;
                    m_shot_req = m_shot_req | new_shot;
                end
            end
            m_new_press = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (syn_hist.size() >= D) begin
                    all_other = 1'b1;
                    for (int i = 1; i <= D; i++) begin
                        if (syn_hist[syn_hist.size()-i][b] == m_level[b]) all_other = 1'b0;
                    end
                    if (all_other) begin
                        m_level[b]     = ~m_level[b];
                        m_new_press[b] = m_level[b];
                    end
                end
            end
            syn_hist.push_back(raw_prev);
            if (syn_hist.size() > D + 2) void'(syn_hist.pop_front());
            raw_prev = raw;
        end
        exp_q.push_back(m_out);
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic [7:0] raw, input logic tick);
        reset      = rst;
        btn_raw    = raw;
        frame_tick = tick;
        @(posedge clk50mhz);
        model_edge(rst, raw, tick);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        obs_t got;
        obs_t want;
        forever begin
            @(negedge clk50mhz);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {left_o, right_o, up_o, shot_o, stable_o};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs @%0t: got l=%b r=%b u=%b s=%b st=%h want l=%b r=%b u=%b s=%b st=%h",
                             $time, got.left, got.right, got.up, got.shot, got.stable,
                             want.left, want.right, want.up, want.shot, want.stable);
                end
            end
        end
    end

    initial begin
        logic [7:0] raw_v;
        int         mode;
        int         len;
        int         odds;

        // Up button of player 1 held through reset, then a 5-cycle glitch on
        // player 0 left, then everything released
        repeat (3) step(1'b1, 8'h40, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 8'h40, (i % 10) == 0);
        for (int i = 0; i < 5; i++)  step(1'b0, 8'h41, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h40, (i % 7) == 3);
        for (int i = 0; i < 30; i++) step(1'b0, 8'h00, (i % 9) == 4);

        // Player 1 shot held across several frames, then released and re-pressed
        for (int i = 0; i < 60; i++) step(1'b0, 8'h80, (i % 12) == 5);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, (i % 12) == 5);
        for (int i = 0; i < 40; i++) step(1'b0, 8'h80, (i % 12) == 5);

        // Left+right conflict, then release right
        for (int i = 0; i < 30; i++) step(1'b0, 8'h03, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 8'h01, 1'b0);

        // Random blocks: bouncy, medium and calm buttons, occasional reset
        raw_v = 8'h01;
        for (int blk = 0; blk < 60; blk++) begin
            mode = int'($urandom_range(0, 2));
            len  = int'($urandom_range(40, 160));
            odds = (mode == 0) ? 3 : ((mode == 1) ? 12 : 50);
            if ($urandom_range(0, 5) == 0) begin
                repeat (int'($urandom_range(1, 3))) step(1'b1, raw_v, 1'b0);
            end
            for (int i = 0; i < len; i++) begin
                for (int b = 0; b < 8; b++) begin
                    if ($urandom_range(0, odds - 1) == 0) raw_v[b] = ~raw_v[b];
                end
                step(1'b0, raw_v, $urandom_range(0, 15) == 0);
            end
        end

        repeat (2) @(negedge clk50mhz);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected samples left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
